// File: rtl/stream_mux_arb.sv
// N-input registered stream multiplexer with explicit-select and round-robin modes.
// An optional packet lock holds the grant on one channel until its last beat is accepted.
module stream_mux_arb #(
    parameter int  N        = 4,
    parameter int  WIDTH    = 8,
    parameter bit  PKT_LOCK = 1'b1,
    localparam int CW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [CW-1:0]      sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [CW-1:0]      out_ch,
    input  logic               out_ready,
    output logic               locked
);

    // Handshake: a beat moves on any edge where valid & ready are both high;
    // valid never waits for ready, and ready may depend on valid only through the grant.

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [CW-1:0]      out_ch_q, out_ch_d;
    logic               locked_q, locked_d;
    logic [CW-1:0]      lock_ch_q, lock_ch_d;
    logic [CW-1:0]      rr_ptr_q, rr_ptr_d;

    logic                 load;
    logic                 grant_vld;
    logic [CW-1:0]        grant_ch;
    logic [N-1:0]         grant;
    logic [(1<<CW)-1:0]   sel_ok;
    logic                 accept;
    logic                 acc_last;
    logic [WIDTH-1:0]     acc_data;
    int                   idx;

    assign load = ~out_valid_q | out_ready;

    // Grant selection: an active lock overrides both modes.
    always_comb begin
        sel_ok    = '0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int i = 0; i < (1 << CW); i++) begin
            sel_ok[i] = (i < N);
        end
        if (locked_q) begin
            grant_vld = 1'b1;
            grant_ch  = lock_ch_q;
        end else if (!mode) begin
            if (sel_ok[sel]) begin
                grant_vld = 1'b1;
                grant_ch  = sel;
            end
        end else begin
            // Walk from farthest to nearest so the nearest requester after rr_ptr wins.
            for (int k = N; k >= 1; k--) begin
                idx = (int'(rr_ptr_q) + k) % N;
                if (in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_ch  = CW'(idx);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = grant_vld && (grant_ch == CW'(i));
        end
    end

    assign in_ready = load ? grant : '0;
    assign accept   = grant_vld & in_valid[grant_ch] & load;
    assign acc_last = in_last[grant_ch];
    assign acc_data = in_data[int'(grant_ch)*WIDTH +: WIDTH];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        locked_d    = locked_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_data;
            out_last_d  = acc_last;
            out_ch_d    = grant_ch;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (PKT_LOCK && accept) begin
            locked_d  = ~acc_last;
            lock_ch_d = grant_ch;
        end
        if (mode && accept && (!PKT_LOCK || acc_last)) begin
            rr_ptr_d = grant_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            locked_q    <= 1'b0;
            lock_ch_q   <= '0;
            rr_ptr_q    <= CW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            locked_q    <= locked_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: a 4-channel instance for the main flows
// and a 3-channel instance for the out-of-range select case.
module tb_stream_mux_arb;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic [1:0]       sel;
    logic [N-1:0]     in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]     in_last;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [1:0]       out_ch;
    logic             out_ready;
    logic             locked;

    logic             mode3;
    logic [1:0]       sel3;
    logic [2:0]       in_valid3;
    logic [3*WIDTH-1:0] in_data3;
    logic [2:0]       in_last3;
    logic [2:0]       in_ready3;
    logic             out_valid3;
    logic [WIDTH-1:0] out_data3;
    logic             out_last3;
    logic [1:0]       out_ch3;
    logic             out_ready3;
    logic             locked3;

    int n_checks = 0;
    int n_errors = 0;

    stream_mux_arb #(.N(N), .WIDTH(WIDTH), .PKT_LOCK(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .out_ready(out_ready), .locked(locked)
    );

    stream_mux_arb #(.N(3), .WIDTH(WIDTH), .PKT_LOCK(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
        .out_ready(out_ready3), .locked(locked3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic v, input logic [WIDTH-1:0] d, input logic l);
        in_valid[i]              = v;
        in_data[i*WIDTH +: WIDTH] = d;
        in_last[i]               = l;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b0;
        sel        = 2'd0;
        in_valid   = '0;
        in_data    = '0;
        in_last    = '0;
        out_ready  = 1'b1;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_valid3  = '0;
        in_data3   = '0;
        in_last3   = '0;
        out_ready3 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;

        // select mode, ch2 streams a 3-beat packet
        sel = 2'd2;
        set_ch(2, 1'b1, 8'h11, 1'b0);
        #1;
        check("sel_in_ready0", 32'(in_ready), 32'b0100);
        tick();
        check("sel_valid1", 32'(out_valid), 32'd1);
        check("sel_data1", 32'(out_data), 32'h11);
        check("sel_ch1", 32'(out_ch), 32'd2);
        check("sel_locked1", 32'(locked), 32'd1);
        set_ch(2, 1'b1, 8'h22, 1'b0);
        #1;
        check("sel_in_ready1", 32'(in_ready), 32'b0100);
        tick();
        check("sel_data2", 32'(out_data), 32'h22);
        set_ch(2, 1'b1, 8'h33, 1'b1);
        tick();
        check("sel_data3", 32'(out_data), 32'h33);
        check("sel_last3", 32'(out_last), 32'd1);
        check("sel_unlock", 32'(locked), 32'd0);
        in_valid = '0;
        tick();
        check("sel_drain_valid", 32'(out_valid), 32'd0);
        check("sel_drain_hold", 32'(out_data), 32'h33);

        // round-robin fairness with single-beat packets
        mode = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 1'b1, 8'(8'hA0 + i), 1'b1);
        for (int b = 0; b < 6; b++) begin
            tick();
            check("rr_ch", 32'(out_ch), 32'(b % 4));
            check("rr_data", 32'(out_data), 32'(8'hA0 + (b % 4)));
        end
        in_valid = '0;
        tick();
        check("rr_drain", 32'(out_valid), 32'd0);

        // packet lock: ch1 holds the output for three beats, with a stall in between
        set_ch(0, 1'b1, 8'h40, 1'b1);
        tick();
        check("lk_pre_ch", 32'(out_ch), 32'd0);
        set_ch(1, 1'b1, 8'h51, 1'b0);
        set_ch(2, 1'b1, 8'hC2, 1'b1);
        #1;
        check("lk_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check("lk_b1_ch", 32'(out_ch), 32'd1);
        check("lk_b1_data", 32'(out_data), 32'h51);
        check("lk_b1_locked", 32'(locked), 32'd1);
        in_valid[1] = 1'b0;
        #1;
        check("lk_stall_ready", 32'(in_ready), 32'b0010);
        tick();
        check("lk_stall_valid", 32'(out_valid), 32'd0);
        check("lk_stall_locked", 32'(locked), 32'd1);
        set_ch(1, 1'b1, 8'h52, 1'b0);
        tick();
        check("lk_b2_ch", 32'(out_ch), 32'd1);
        check("lk_b2_data", 32'(out_data), 32'h52);
        set_ch(1, 1'b1, 8'h53, 1'b1);
        tick();
        check("lk_b3_data", 32'(out_data), 32'h53);
        check("lk_b3_ch", 32'(out_ch), 32'd1);
        check("lk_b3_unlock", 32'(locked), 32'd0);
        tick();
        check("lk_next_ch", 32'(out_ch), 32'd2);
        check("lk_next_data", 32'(out_data), 32'hC2);
        in_valid = '0;
        tick();

        // backpressure in select mode on ch0
        mode = 1'b0;
        sel  = 2'd0;
        set_ch(0, 1'b1, 8'h61, 1'b1);
        tick();
        check("bp_first", 32'(out_data), 32'h61);
        out_ready = 1'b0;
        set_ch(0, 1'b1, 8'h62, 1'b1);
        #1;
        check("bp_ready_low", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_data", 32'(out_data), 32'h61);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ready", 32'(in_ready), 32'b0001);
        tick();
        check("bp_data2", 32'(out_data), 32'h62);
        set_ch(0, 1'b1, 8'h63, 1'b1);
        tick();
        check("bp_data3", 32'(out_data), 32'h63);
        set_ch(0, 1'b1, 8'h64, 1'b1);
        tick();
        check("bp_data4", 32'(out_data), 32'h64);
        in_valid = '0;
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        // out-of-range select on the 3-channel instance
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        in_last3  = 3'b111;
        in_data3  = 24'h332211;
        #1;
        check("n3_sel3_ready", 32'(in_ready3), 32'd0);
        tick();
        check("n3_sel3_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd1;
        #1;
        check("n3_sel1_ready", 32'(in_ready3), 32'b010);
        tick();
        check("n3_sel1_valid", 32'(out_valid3), 32'd1);
        check("n3_sel1_data", 32'(out_data3), 32'h22);
        in_valid3 = '0;

        // asynchronous reset mid-packet
        mode = 1'b1;
        set_ch(1, 1'b1, 8'h71, 1'b0);
        tick();
        check("ar_pre_locked", 32'(locked), 32'd1);
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_locked", 32'(locked), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 1'b1, 8'(8'hB0 + i), 1'b1);
        tick();
        check("ar_first_ch", 32'(out_ch), 32'd0);
        check("ar_first_data", 32'(out_data), 32'hB0);
        in_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
